// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Merges N_CH channel bytes into one UART TX FIFO write port. A channel is sent
// only when its value differs from the value last sent for it. Channels are
// served round-robin, starting after the most recently sent channel. tx_full
// holds off new grants. Every write is followed by GAP_CYCLES idle cycles, so
// the FIFO's tx_full flag has time to catch up.
//
// Optional feature: define UART_KEEPALIVE_EN to add a periodic resend of every
// enabled channel every REFRESH_CYCLES clocks, which lets the peer resync.
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   ch_data   N_CH*DATA_W; channel i occupies bits [i*DATA_W +: DATA_W]
//   ch_en     per-channel enable; a disabled channel is never granted
//   tx_full   UART TX FIFO full flag
//   w_data    byte presented to the FIFO
//   wr_uart   one-cycle FIFO write strobe
//   last_ch   index of the most recently sent channel
//   busy      high while in SEND or GAP
//   sent_cnt  total bytes written, saturating at all-ones
module uart_tx_arbiter #(
  parameter int N_CH           = 4,
  parameter int DATA_W         = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int REFRESH_CYCLES = 650000,
  parameter int CNT_W          = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic [N_CH-1:0]          ch_en,
  input  logic                     tx_full,
  output logic [DATA_W-1:0]        w_data,
  output logic                     wr_uart,
  output logic [$clog2(N_CH)-1:0]  last_ch,
  output logic                     busy,
  output logic [CNT_W-1:0]         sent_cnt
);

  localparam int CH_W  = $clog2(N_CH);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  logic [1:0]        state;
  logic [GAP_W-1:0]  gap_cnt;
  logic [DATA_W-1:0] last_sent [N_CH];
  logic [N_CH-1:0]   refresh;
  logic [N_CH-1:0]   pending;
  logic [CH_W-1:0]   grant;
  logic              grant_vld;
  logic [DATA_W-1:0] grant_data;
  logic              start;

  // A channel wants service when it is enabled and its value is new, or when a
  // keep-alive resend has been requested for it.
  always_comb begin
    pending = '0;
    for (int i = 0; i < N_CH; i++) begin
      pending[i] = ch_en[i] &
                   ((ch_data[i*DATA_W +: DATA_W] != last_sent[i]) | refresh[i]);
    end
  end

  // The round-robin search order is last_ch+1, last_ch+2, ... with wrap. The
  // loop runs from the farthest candidate down to the nearest one. The nearest
  // pending channel is therefore the last one assigned, and it wins.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    for (int k = N_CH; k >= 1; k--) begin
      if (pending[(int'(last_ch) + k) % N_CH]) begin
        grant     = CH_W'((int'(last_ch) + k) % N_CH);
        grant_vld = 1'b1;
      end
    end
  end

  assign grant_data = ch_data[int'(grant)*DATA_W +: DATA_W];
  assign start      = (state == ST_IDLE) && grant_vld && !tx_full;

  // The strobe is decoded from the state register. An asynchronous reset
  // therefore removes it immediately and aborts the write.
  assign wr_uart = (state == ST_SEND);
  assign busy    = (state == ST_SEND) || (state == ST_GAP);

  // NOTE: sequential state uses non-blocking assignments only. Every register
  // samples pre-edge values, so the result does not depend on the order in
  // which the always blocks are evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      gap_cnt  <= '0;
      w_data   <= '0;
      last_ch  <= CH_W'(N_CH - 1);
      sent_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SEND;
            w_data  <= grant_data;
            last_ch <= grant;
          end
        end
        ST_SEND: begin
          state   <= ST_GAP;
          gap_cnt <= '0;
          if (sent_cnt != '1) sent_cnt <= sent_cnt + 1'b1;
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else                     gap_cnt <= gap_cnt + 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: this small per-channel store is reset on purpose. After reset, the
  // comparison against zero defines what counts as "changed", so every
  // channel that holds a nonzero value is sent once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_CH; i++) last_sent[i] <= '0;
    end else if (start) begin
      last_sent[grant] <= grant_data;
    end
  end

`ifdef UART_KEEPALIVE_EN
  localparam int REF_W = $clog2(REFRESH_CYCLES);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  logic [REF_W-1:0] refresh_cnt;
  logic             refresh_wrap;

  assign refresh_wrap = (refresh_cnt == REF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) refresh_cnt <= '0;
    else     refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
  end

  // A wrap has priority over the clear-on-grant. A refresh that lands on the
  // same cycle as a grant of that channel is kept, and the channel is resent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (refresh_wrap && ch_en[i])               refresh[i] <= 1'b1;
        else if (start && (int'(grant) == i))       refresh[i] <= 1'b0;
      end
    end
  end
`else
  assign refresh = '0;
  // REFRESH_CYCLES is intentionally not used when keep-alive is compiled out.
  logic unused_refresh_cfg;
  assign unused_refresh_cfg = (REFRESH_CYCLES != 0);
`endif

endmodule
